nonce_scheduler: RTL and testbench
==================================

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 Parameter NUM_NONCES, default 16, meaning nonces swept per job (1..16, values 0..NUM_NONCES-1).
REQ-002 Parameter TIMEOUT_CYC, default 80, meaning max cycles from worker_start to worker_finish before error.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-006 midstate[8]  in  32 each  phase-1 digest; sampled on accepted start.
REQ-007 msg_tail[3]  in  32 each  header words 16..18; sampled on accepted start.
REQ-008 busy  out  1  high from accepted start until done pulse.
REQ-009 done  out  1  one-cycle pulse when job completes or aborts.
REQ-010 error  out  1  sticky timeout flag; cleared by next accepted start.
REQ-011 worker_start  out  1  one-cycle start pulse to the shared SHA-256 worker.
REQ-012 worker_phase_sel  out  1  0 = phase 2 (header tail + nonce), 1 = phase 3 (hash of hash).
REQ-013 worker_nonce  out  4  current nonce.
REQ-014 worker_hi[8]  out  32 each  worker initial hash / phase-3 message.
REQ-015 worker_msg_tail[3]  out  32 each  latched msg_tail.
REQ-016 worker_ho[8]  in  32 each  worker digest, valid when worker_finish high.
REQ-017 worker_finish  in  1  one-cycle worker completion pulse.
REQ-018 result_valid  out  1  result available.
REQ-019 result_ready  in  1  consumer accepts when both high.
REQ-020 result_nonce  out  4  nonce of result.
REQ-021 result_h0  out  32  word 0 of final (phase-3) digest.

Function
REQ-022 States: IDLE, P2_GO, P2_WAIT, P3_GO, P3_WAIT, EMIT, FIN.
- IDLE->P2_GO: start; latches inputs, nonce=0, error=0.
REQ-023 P2_GO: worker_start=1 one cycle, phase_sel=0, worker_hi=latched midstate; ->P2_WAIT next cycle.
REQ-024 P2_WAIT: on worker_finish latch worker_ho into hash2[8]; ->P3_GO.
REQ-025 P3_GO: worker_start=1 one cycle, phase_sel=1, worker_hi=hash2; ->P3_WAIT.
REQ-026 P3_WAIT: on worker_finish latch result_h0=worker_ho[0], result_nonce=nonce; ->EMIT.
REQ-027 EMIT: result_valid=1, outputs held stable until result_ready.
- On handshake: last nonce (NUM_NONCES-1) ->FIN, else nonce+1 ->P2_GO the next cycle.
REQ-028 FIN: done=1 one cycle, busy=0 in the same cycle; ->IDLE.
REQ-029 worker_phase_sel, worker_nonce, worker_hi, worker_msg_tail stable from GO cycle until worker_finish.
REQ-030 Timeout counter resets on every GO state, increments in WAIT states.
- Reaching TIMEOUT_CYC with no finish: error=1, abort ->FIN; no result emitted.
REQ-031 worker_finish outside a WAIT state is ignored.
REQ-032 start outside IDLE is ignored; no queuing.
REQ-033 Job latency with result_ready tied high: per nonce = 2 worker runs + 3 cycles (GO, GO, EMIT).
REQ-034 Nonce counter does not wrap. Sweep ends at NUM_NONCES-1.

Reset
REQ-035 Asynchronous reset_n low: state=IDLE.
- All outputs low/zero: busy, done, error, worker_start, result_valid, nonce, result_h0.
REQ-036 Reset mid-job abandons the job without a done pulse.
- The worker is restarted by the next GO state.

Configuration
REQ-037 Macro NONCE_SCHED_TARGET_CMP_EN.
- When defined: adds input target (32) and outputs found (1), found_nonce (4).
- In P3_WAIT, found=1 (sticky per job) and found_nonce latched for the first nonce with worker_ho[0] < target.
- The same compare is unsigned.
REQ-038 Without NONCE_SCHED_TARGET_CMP_EN, those ports and the compare logic are absent. All other behaviour is identical.

Verification
REQ-039 NUM_NONCES=16, result_ready=1, worker model with finish 66 cycles after start:
- 16 results with nonce 0..15 in order.
- done pulses once.
- busy low only after done.
REQ-040 result_ready low 10 cycles at nonce 3:
- result_valid, result_nonce=3 and result_h0 stay stable for those 10 cycles.
- No worker_start is issued until the handshake.
REQ-041 Worker model never asserts finish:
- error=1 and done pulse at TIMEOUT_CYC cycles after the P2 worker_start.
- No result_valid.
- The next start clears error.
REQ-042 reset_n low during P3_WAIT of nonce 5:
- All outputs zero immediately.
- A new start restarts at nonce 0.
REQ-043 With NONCE_SCHED_TARGET_CMP_EN and target=32'h00001000, model returning h0=32'h00000FFF at nonce 9 and 32'h00000001 at nonce 12:
- found=1.
- found_nonce=9.
REQ-044 start pulsed while busy and a spurious worker_finish in EMIT:
- Both ignored.
- Sequence unchanged.

Source files
------------

// File: rtl/nonce_scheduler.sv
// Sequences one shared SHA-256 worker through phase-2/phase-3 runs for each nonce of a mining job.
// Optional target comparison is compiled in with NONCE_SCHED_TARGET_CMP_EN.
module nonce_scheduler #(
   parameter int NUM_NONCES  = 16,
   parameter int TIMEOUT_CYC = 80
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] midstate [8],
   input  logic [31:0] msg_tail [3],
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        worker_start,
   output logic        worker_phase_sel,
   output logic [3:0]  worker_nonce,
   output logic [31:0] worker_hi [8],
   output logic [31:0] worker_msg_tail [3],
   input  logic [31:0] worker_ho [8],
   input  logic        worker_finish,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [3:0]  result_nonce,
   output logic [31:0] result_h0
`ifdef NONCE_SCHED_TARGET_CMP_EN
   ,
   input  logic [31:0] target,
   output logic        found,
   output logic [3:0]  found_nonce
`endif
);

   localparam logic [3:0] LAST_NONCE = 4'(NUM_NONCES - 1);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   // GO cycle counts as cycle 0, so the last allowed WAIT cycle sees cnt = TIMEOUT_CYC-2
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 2);

   typedef enum logic [2:0] {IDLE, P2_GO, P2_WAIT, P3_GO, P3_WAIT, EMIT, FIN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       nonce;
   logic [31:0]      mid_q  [8];
   logic [31:0]      tail_q [3];
   logic [31:0]      hash2  [8];
   logic             in_wait, timeout, accept, handshake;

   assign in_wait   = (state == P2_WAIT) || (state == P3_WAIT);
   assign timeout   = in_wait && !worker_finish && (cnt == CNT_LIM);
   assign accept    = (state == IDLE) && start;
   assign handshake = (state == EMIT) && result_ready;

   always_comb begin
      state_nxt        = state;
      busy             = 1'b1;
      done             = 1'b0;
      worker_start     = 1'b0;
      worker_phase_sel = 1'b0;
      result_valid     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = P2_GO;
         end
         P2_GO: begin
            worker_start = 1'b1;
            state_nxt    = P2_WAIT;
         end
         P2_WAIT: begin
            if (worker_finish) state_nxt = P3_GO;
            else if (timeout)  state_nxt = FIN;
         end
         P3_GO: begin
            worker_start     = 1'b1;
            worker_phase_sel = 1'b1;
            state_nxt        = P3_WAIT;
         end
         P3_WAIT: begin
            worker_phase_sel = 1'b1;
            if (worker_finish) state_nxt = EMIT;
            else if (timeout)  state_nxt = FIN;
         end
         EMIT: begin
            result_valid = 1'b1;
            if (result_ready) state_nxt = (nonce == LAST_NONCE) ? FIN : P2_GO;
         end
         FIN: begin
            busy      = 1'b0;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         nonce        <= '0;
         error        <= 1'b0;
         result_nonce <= '0;
         result_h0    <= '0;
      end else begin
         state <= state_nxt;
         if ((state == P2_GO) || (state == P3_GO)) cnt <= '0;
         else if (in_wait)                        cnt <= cnt + 1'b1;
         if (accept) begin
            nonce <= '0;
            error <= 1'b0;
         end
         if (timeout) error <= 1'b1;
         if (handshake && (nonce != LAST_NONCE)) nonce <= nonce + 1'b1;
         if ((state == P3_WAIT) && worker_finish) begin
            result_h0    <= worker_ho[0];
            result_nonce <= nonce;
         end
      end
   end

   // Payload registers carry no reset; they are always rewritten before use
   always_ff @(posedge clk) begin
      if (accept) begin
         mid_q  <= midstate;
         tail_q <= msg_tail;
      end
      if ((state == P2_WAIT) && worker_finish) hash2 <= worker_ho;
   end

`ifdef NONCE_SCHED_TARGET_CMP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         found       <= 1'b0;
         found_nonce <= '0;
      end else if (accept) begin
         found       <= 1'b0;
         found_nonce <= '0;
      end else if ((state == P3_WAIT) && worker_finish && !found && (worker_ho[0] < target)) begin
         found       <= 1'b1;
         found_nonce <= nonce;
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < 8; i++) worker_hi[i] = worker_phase_sel ? hash2[i] : mid_q[i];
   end

   assign worker_msg_tail = tail_q;
   assign worker_nonce    = nonce;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: behavioural worker model plus a job-level reference.
module tb_nonce_scheduler;
   localparam int N   = 16;
   localparam int TMO = 80;

   logic        clk = 1'b0;
   logic        reset_n, start, busy, done, error, worker_start, worker_phase_sel;
   logic [31:0] midstate [8];
   logic [31:0] msg_tail [3];
   logic [3:0]  worker_nonce, result_nonce;
   logic [31:0] worker_hi [8];
   logic [31:0] worker_msg_tail [3];
   logic [31:0] worker_ho [8];
   logic        worker_finish, result_valid, result_ready;
   logic [31:0] result_h0;
`ifdef NONCE_SCHED_TARGET_CMP_EN
   logic [31:0] target;
   logic        found;
   logic [3:0]  found_nonce;
`endif

   int checks = 0, failures = 0;
   logic [255:0] job_mid;
   logic [95:0]  job_tail;
   int  wk_delay;
   bit  wk_never, spur_en;
   logic [15:0] ov_en;
   logic [31:0] ov_val [16];
   logic [3:0]  res_n_log [256];
   logic [31:0] res_h_log [256];
   int res_total = 0, done_total = 0, valid_total = 0;

   always #5 clk = ~clk;

   nonce_scheduler #(.NUM_NONCES(N), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .midstate(midstate), .msg_tail(msg_tail),
      .busy(busy), .done(done), .error(error), .worker_start(worker_start),
      .worker_phase_sel(worker_phase_sel), .worker_nonce(worker_nonce), .worker_hi(worker_hi),
      .worker_msg_tail(worker_msg_tail), .worker_ho(worker_ho), .worker_finish(worker_finish),
      .result_valid(result_valid), .result_ready(result_ready), .result_nonce(result_nonce),
      .result_h0(result_h0)
`ifdef NONCE_SCHED_TARGET_CMP_EN
      , .target(target), .found(found), .found_nonce(found_nonce)
`endif
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stand-in for SHA-256: a cheap mix of initial hash, nonce, phase and tail
   function automatic logic [31:0] fw(input logic ph, input logic [3:0] n, input logic [255:0] hi,
                                      input logic [95:0] tl, input int k);
      logic [31:0] w;
      w = hi[k*32 +: 32];
      return (w ^ (32'h9E3779B9 * 32'(k + 1))) + ({28'd0, n} * 32'h01000193)
             + (ph ? 32'h5A5A0F0F : tl[(k % 3)*32 +: 32]);
   endfunction

   function automatic logic [255:0] h2_of(input logic [3:0] n);
      logic [255:0] h;
      for (int k = 0; k < 8; k++) h[k*32 +: 32] = fw(1'b0, n, job_mid, job_tail, k);
      return h;
   endfunction

   function automatic logic [31:0] ref_h0(input int n);
      if (ov_en[n]) return ov_val[n];
      return fw(1'b1, 4'(n), h2_of(4'(n)), job_tail, 0);
   endfunction

   initial begin : worker_model
      int wcnt;
      bit pend, spur_done, cap_ph;
      logic [3:0]   cap_n;
      logic [255:0] cap_hi, cur_hi, exp_hi;
      logic [95:0]  cap_tl, cur_tl;
      pend = 0; wcnt = 0; spur_done = 0; worker_finish = 0;
      for (int k = 0; k < 8; k++) worker_ho[k] = '0;
      forever begin
         @(negedge clk);
         worker_finish = 1'b0;
         for (int k = 0; k < 8; k++) cur_hi[k*32 +: 32] = worker_hi[k];
         for (int k = 0; k < 3; k++) cur_tl[k*32 +: 32] = worker_msg_tail[k];
         if (!spur_en) spur_done = 0;
         if (!reset_n) pend = 0;
         else begin
            if (pend) begin
               wcnt--;
               if (wcnt == 0) begin
                  pend = 0;
                  chk("wk_stable_hi", cur_hi, cap_hi);
                  chk("wk_stable_tail", 256'(cur_tl), 256'(cap_tl));
                  chk("wk_stable_nonce", 256'(worker_nonce), 256'(cap_n));
                  chk("wk_stable_phase", 256'(worker_phase_sel), 256'(cap_ph));
                  for (int k = 0; k < 8; k++)
                     worker_ho[k] = (cap_ph && k == 0 && ov_en[cap_n]) ? ov_val[cap_n]
                                                                       : fw(cap_ph, cap_n, cap_hi, cap_tl, k);
                  worker_finish = 1'b1;
               end
            end else if (spur_en && !spur_done && result_valid) begin
               spur_done = 1;
               for (int k = 0; k < 8; k++) worker_ho[k] = $urandom;
               worker_finish = 1'b1;
            end
            if (worker_start) begin
               cap_ph = worker_phase_sel; cap_n = worker_nonce; cap_hi = cur_hi; cap_tl = cur_tl;
               exp_hi = cap_ph ? h2_of(cap_n) : job_mid;
               chk("wk_start_hi", cur_hi, exp_hi);
               chk("wk_start_tail", 256'(cur_tl), 256'(job_tail));
               if (!wk_never) begin
                  pend = 1;
                  wcnt = wk_delay;
               end
            end
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         #1;
         if (reset_n) begin
            if (result_valid && result_ready) begin
               if (res_total < 256) begin
                  res_n_log[res_total] = result_nonce;
                  res_h_log[res_total] = result_h0;
               end
               res_total++;
            end
            if (done) done_total++;
            if (result_valid) valid_total++;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic new_job_data();
      for (int k = 0; k < 8; k++) job_mid[k*32 +: 32] = $urandom;
      for (int k = 0; k < 3; k++) job_tail[k*32 +: 32] = $urandom;
      for (int k = 0; k < 8; k++) midstate[k] = job_mid[k*32 +: 32];
      for (int k = 0; k < 3; k++) msg_tail[k] = job_tail[k*32 +: 32];
   endtask

   task automatic run_job(input int hold_n, input bit spur);
      int t, drop, base_res, base_done, nres, exp_dur;
      bit seen, held;
      logic [3:0]  hn;
      logic [31:0] hh;
      new_job_data();
      spur_en = spur;
      base_res = res_total; base_done = done_total;
      t = 0; drop = 0; seen = 0; held = 0;
      start = 1'b1;
      while (t < 6000 && !seen) begin
         @(negedge clk);
         t++;
         if (t == 1) begin
            start = 1'b0;
            chk("go_busy", 256'(busy), 256'(1));
            chk("go_worker_start", 256'(worker_start), 256'(1));
            chk("go_error_clear", 256'(error), 256'(0));
         end
         if (done) seen = 1;
         else begin
            if (!busy) drop++;
            if (spur && t == 50) begin
               start = 1'b1;
               for (int k = 0; k < 8; k++) midstate[k] = $urandom;
            end
            if (spur && t == 51) start = 1'b0;
            if (hold_n >= 0 && !held && result_valid && result_nonce == 4'(hold_n)) begin
               held = 1; hn = result_nonce; hh = result_h0; result_ready = 1'b0;
               for (int i = 0; i < 10; i++) begin
                  @(negedge clk);
                  t++;
                  chk("hold_valid", 256'(result_valid), 256'(1));
                  chk("hold_nonce", 256'(result_nonce), 256'(hn));
                  chk("hold_h0", 256'(result_h0), 256'(hh));
                  chk("hold_no_worker_start", 256'(worker_start), 256'(0));
               end
               result_ready = 1'b1;
            end
         end
      end
      spur_en = 0;
      exp_dur = 1 + N * (2 * wk_delay + 3) + ((hold_n >= 0) ? 10 : 0);
      chk("job_done_seen", 256'(seen), 256'(1));
      chk("job_latency", 256'(t), 256'(exp_dur));
      chk("busy_low_before_done", 256'(drop), 256'(0));
      @(negedge clk);
      @(negedge clk);
      chk("done_once", 256'(done_total - base_done), 256'(1));
      chk("idle_busy", 256'(busy), 256'(0));
      nres = res_total - base_res;
      chk("result_count", 256'(nres), 256'(N));
      for (int i = 0; i < N && i < nres; i++) begin
         chk("result_nonce", 256'(res_n_log[base_res + i]), 256'(i));
         chk("result_h0", 256'(res_h_log[base_res + i]), 256'(ref_h0(i)));
      end
   endtask

   initial begin : main
      int t, ws, dt, base_valid, base_done;
      bit hit;
      reset_n = 1'b0; start = 1'b0; result_ready = 1'b1;
      for (int k = 0; k < 8; k++) midstate[k] = '0;
      for (int k = 0; k < 3; k++) msg_tail[k] = '0;
      job_mid = '0; job_tail = '0;
      wk_delay = 66; wk_never = 0; spur_en = 0; ov_en = '0;
      for (int k = 0; k < 16; k++) ov_val[k] = '0;
`ifdef NONCE_SCHED_TARGET_CMP_EN
      target = '0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      chk("rst_error", 256'(error), 256'(0));
      chk("rst_worker_start", 256'(worker_start), 256'(0));
      chk("rst_result_valid", 256'(result_valid), 256'(0));
      chk("rst_nonce", 256'(worker_nonce), 256'(0));
      chk("rst_result_h0", 256'(result_h0), 256'(0));
      reset_n = 1'b1;
      @(negedge clk);

      run_job(-1, 1'b0);
      run_job(3, 1'b0);
      run_job(-1, 1'b1);

      // Worker that never finishes: abort after TMO cycles, no results
      wk_never = 1;
      new_job_data();
      base_valid = valid_total; base_done = done_total;
      t = 0; ws = -1; dt = -1;
      start = 1'b1;
      while (t < 400 && dt < 0) begin
         @(negedge clk);
         t++;
         if (t == 1) start = 1'b0;
         if (worker_start && ws < 0) ws = t;
         if (done) begin
            dt = t;
            chk("tmo_error_at_done", 256'(error), 256'(1));
            chk("tmo_busy_at_done", 256'(busy), 256'(0));
         end
      end
      chk("tmo_done_seen", 256'(dt > 0), 256'(1));
      chk("tmo_latency", 256'(dt - ws), 256'(TMO));
      repeat (3) @(negedge clk);
      chk("tmo_error_sticky", 256'(error), 256'(1));
      chk("tmo_no_result", 256'(valid_total - base_valid), 256'(0));
      chk("tmo_done_once", 256'(done_total - base_done), 256'(1));
      wk_never = 0;
      run_job(-1, 1'b0);

      // Reset in the middle of P3_WAIT for nonce 5
      new_job_data();
      t = 0; hit = 0;
      start = 1'b1;
      while (t < 3000 && !hit) begin
         @(negedge clk);
         t++;
         if (t == 1) start = 1'b0;
         if (worker_start && worker_phase_sel && worker_nonce == 4'd5) hit = 1;
      end
      chk("rst_reached_p3_n5", 256'(hit), 256'(1));
      repeat (5) @(negedge clk);
      base_done = done_total;
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 256'(busy), 256'(0));
      chk("midrst_done", 256'(done), 256'(0));
      chk("midrst_error", 256'(error), 256'(0));
      chk("midrst_worker_start", 256'(worker_start), 256'(0));
      chk("midrst_result_valid", 256'(result_valid), 256'(0));
      chk("midrst_nonce", 256'(worker_nonce), 256'(0));
      chk("midrst_result_h0", 256'(result_h0), 256'(0));
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk("midrst_no_done", 256'(done_total - base_done), 256'(0));
      @(negedge clk);
      run_job(-1, 1'b0);

`ifdef NONCE_SCHED_TARGET_CMP_EN
      chk("found_clear_zero_target", 256'(found), 256'(0));
      target = 32'h0000_1000;
      ov_en = '1;
      for (int n = 0; n < 16; n++) ov_val[n] = 32'hFFFF_0000 | 32'(n);
      ov_val[9]  = 32'h0000_0FFF;
      ov_val[12] = 32'h0000_0001;
      run_job(-1, 1'b0);
      chk("found", 256'(found), 256'(1));
      chk("found_nonce", 256'(found_nonce), 256'(9));
      ov_en = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
